// File: rtl/lsu_axi_master_bridge.sv
// Bridges the LSU request/response port to single-beat AXI4 master transactions, one outstanding.
// Optional response error checking is enabled by defining LSU_AXI_BRIDGE_ERR_CHECK_EN.
module lsu_axi_master_bridge #(
  parameter int AXI_ADDR_W = 64,
  parameter int AXI_ID_W   = 8,
  parameter int AXI_DATA_W = 64,
  parameter logic [AXI_ID_W-1:0] BRIDGE_ID = '0
) (
  input  logic                    aclk,
  input  logic                    arst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [AXI_ADDR_W-1:0]   req_addr,
  input  logic [2:0]              req_size,
  input  logic [AXI_DATA_W-1:0]   req_wdata,
  input  logic [AXI_DATA_W/8-1:0] req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [AXI_DATA_W-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    mst_awvalid,
  input  logic                    mst_awready,
  output logic [AXI_ADDR_W-1:0]   mst_awaddr,
  output logic [7:0]              mst_awlen,
  output logic [2:0]              mst_awsize,
  output logic [1:0]              mst_awburst,
  output logic                    mst_awlock,
  output logic [3:0]              mst_awcache,
  output logic [2:0]              mst_awprot,
  output logic [3:0]              mst_awqos,
  output logic [3:0]              mst_awregion,
  output logic [AXI_ID_W-1:0]     mst_awid,
  output logic                    mst_wvalid,
  input  logic                    mst_wready,
  output logic [AXI_DATA_W-1:0]   mst_wdata,
  output logic [AXI_DATA_W/8-1:0] mst_wstrb,
  output logic                    mst_wlast,
  input  logic                    mst_bvalid,
  output logic                    mst_bready,
  input  logic [AXI_ID_W-1:0]     mst_bid,
  input  logic [1:0]              mst_bresp,
  output logic                    mst_arvalid,
  input  logic                    mst_arready,
  output logic [AXI_ADDR_W-1:0]   mst_araddr,
  output logic [7:0]              mst_arlen,
  output logic [2:0]              mst_arsize,
  output logic [1:0]              mst_arburst,
  output logic                    mst_arlock,
  output logic [3:0]              mst_arcache,
  output logic [2:0]              mst_arprot,
  output logic [3:0]              mst_arqos,
  output logic [3:0]              mst_arregion,
  output logic [AXI_ID_W-1:0]     mst_arid,
  input  logic                    mst_rvalid,
  output logic                    mst_rready,
  input  logic [AXI_ID_W-1:0]     mst_rid,
  input  logic [1:0]              mst_rresp,
  input  logic [AXI_DATA_W-1:0]   mst_rdata,
  input  logic                    mst_rlast
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RD, S_RW, S_RESP} state_t;

  state_t                  state;
  logic [AXI_ADDR_W-1:0]   addr_q;
  logic [2:0]              size_q;
  logic [AXI_DATA_W-1:0]   wdata_q;
  logic [AXI_DATA_W/8-1:0] wstrb_q;
  logic                    aw_done;
  logic                    w_done;
  logic                    aw_hs;
  logic                    w_hs;

  assign aw_hs     = mst_awvalid & mst_awready;
  assign w_hs      = mst_wvalid & mst_wready;
  assign req_ready = (state == S_IDLE);

  assign mst_awaddr   = addr_q;
  assign mst_awlen    = 8'h00;
  assign mst_awsize   = size_q;
  assign mst_awburst  = 2'h1;
  assign mst_awlock   = 1'b0;
  assign mst_awcache  = 4'h0;
  assign mst_awprot   = 3'h0;
  assign mst_awqos    = 4'h0;
  assign mst_awregion = 4'h0;
  assign mst_awid     = BRIDGE_ID;
  assign mst_wdata    = wdata_q;
  assign mst_wstrb    = wstrb_q;
  assign mst_wlast    = 1'b1;
  assign mst_araddr   = addr_q;
  assign mst_arlen    = 8'h00;
  assign mst_arsize   = size_q;
  assign mst_arburst  = 2'h1;
  assign mst_arlock   = 1'b0;
  assign mst_arcache  = 4'h0;
  assign mst_arprot   = 3'h0;
  assign mst_arqos    = 4'h0;
  assign mst_arregion = 4'h0;
  assign mst_arid     = BRIDGE_ID;

`ifndef LSU_AXI_BRIDGE_ERR_CHECK_EN
  logic unused_resp_fields;
  assign unused_resp_fields = ^{mst_bid, mst_bresp, mst_rid, mst_rresp, mst_rlast};
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      mst_awvalid <= 1'b0;
      mst_wvalid  <= 1'b0;
      mst_bready  <= 1'b0;
      mst_arvalid <= 1'b0;
      mst_rready  <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
`ifdef LSU_AXI_BRIDGE_ERR_CHECK_EN
      resp_err    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
            if (req_we) begin
              state       <= S_WR;
              mst_awvalid <= 1'b1;
              mst_wvalid  <= 1'b1;
            end else begin
              state       <= S_RD;
              mst_arvalid <= 1'b1;
            end
          end
        end
        S_WR: begin
          // AW and W complete independently; a handshake this cycle counts as done
          if (aw_hs) begin
            mst_awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_hs) begin
            mst_wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state      <= S_WB;
            mst_bready <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
          end
        end
        S_WB: begin
          if (mst_bvalid) begin
            state      <= S_RESP;
            mst_bready <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
`ifdef LSU_AXI_BRIDGE_ERR_CHECK_EN
            resp_err   <= (mst_bresp != 2'h0) || (mst_bid != BRIDGE_ID);
`endif
          end
        end
        S_RD: begin
          if (mst_arready) begin
            state       <= S_RW;
            mst_arvalid <= 1'b0;
            mst_rready  <= 1'b1;
          end
        end
        S_RW: begin
          if (mst_rvalid) begin
            state      <= S_RESP;
            mst_rready <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= mst_rdata;
`ifdef LSU_AXI_BRIDGE_ERR_CHECK_EN
            resp_err   <= (mst_rresp != 2'h0) || (mst_rid != BRIDGE_ID) || !mst_rlast;
`endif
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
